// File: rtl/axi_read_arbiter.sv
// Two-master AXI4 read-channel arbiter: video (master 0) has priority, a streak
// counter guarantees CPU (master 1) progress. One burst in flight, so R needs no IDs.
module axi_read_arbiter #(
    parameter int VIDEO_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_ar_valid,
    output logic        m0_ar_ready,
    input  logic [31:0] m0_ar_payload_addr,
    input  logic [7:0]  m0_ar_payload_len,
    input  logic [1:0]  m0_ar_payload_burst,
    output logic        m0_r_valid,
    input  logic        m0_r_ready,
    output logic [31:0] m0_r_payload_data,
    output logic        m0_r_payload_last,

    input  logic        m1_ar_valid,
    output logic        m1_ar_ready,
    input  logic [31:0] m1_ar_payload_addr,
    input  logic [7:0]  m1_ar_payload_len,
    input  logic [1:0]  m1_ar_payload_burst,
    output logic        m1_r_valid,
    input  logic        m1_r_ready,
    output logic [31:0] m1_r_payload_data,
    output logic        m1_r_payload_last,

    output logic        s_ar_valid,
    input  logic        s_ar_ready,
    output logic [31:0] s_ar_payload_addr,
    output logic [7:0]  s_ar_payload_len,
    output logic [1:0]  s_ar_payload_burst,
    input  logic        s_r_valid,
    output logic        s_r_ready,
    input  logic [31:0] s_r_payload_data,
    input  logic        s_r_payload_last,

    output logic        grant,
    output logic        len_error
);

    localparam int SW = (VIDEO_STREAK > 0) ? $clog2(VIDEO_STREAK + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(VIDEO_STREAK);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
    } ar_req_t;

    state_t        state;
    ar_req_t       req;
    logic [SW-1:0] streak;
    logic [8:0]    beat_cnt;

    logic starve;
    logic win1;
    logic in_data;
    logic beat;
    logic [8:0] len_ext;

    // Master 1 takes the slot when video is absent or video has used up its streak.
    assign starve = (VIDEO_STREAK != 0) && (streak == STREAK_MAX) && m1_ar_valid;
    assign win1   = m1_ar_valid && (!m0_ar_valid || starve);

    assign m0_ar_ready = reset_n && (state == IDLE) && m0_ar_valid && !win1;
    assign m1_ar_ready = reset_n && (state == IDLE) && win1;

    assign s_ar_payload_addr  = req.addr;
    assign s_ar_payload_len   = req.len;
    assign s_ar_payload_burst = req.burst;

    assign in_data    = (state == DATA);
    assign s_r_ready  = in_data && (grant ? m1_r_ready : m0_r_ready);
    assign m0_r_valid = in_data && !grant && s_r_valid;
    assign m1_r_valid = in_data && grant && s_r_valid;

    assign m0_r_payload_data = s_r_payload_data;
    assign m1_r_payload_data = s_r_payload_data;
    assign m0_r_payload_last = s_r_payload_last;
    assign m1_r_payload_last = s_r_payload_last;

    assign beat    = s_r_valid && s_r_ready;
    assign len_ext = {1'b0, req.len};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req        <= '0;
            s_ar_valid <= 1'b0;
            grant      <= 1'b0;
            streak     <= '0;
            beat_cnt   <= '0;
            len_error  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_ar_ready || m1_ar_ready) begin
                        req        <= m1_ar_ready ?
                                      '{m1_ar_payload_addr, m1_ar_payload_len, m1_ar_payload_burst} :
                                      '{m0_ar_payload_addr, m0_ar_payload_len, m0_ar_payload_burst};
                        s_ar_valid <= 1'b1;
                        grant      <= m1_ar_ready;
                        state      <= ADDR;
                        if (m1_ar_ready || !m1_ar_valid)
                            streak <= '0;
                        else if (streak != STREAK_MAX)
                            streak <= streak + 1'b1;
                    end
                end
                ADDR: begin
                    if (s_ar_ready) begin
                        s_ar_valid <= 1'b0;
                        beat_cnt   <= '0;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        if (s_r_payload_last) begin
                            if (beat_cnt != len_ext)
                                len_error <= 1'b1;
                            state <= IDLE;
                        end else if (beat_cnt == len_ext + 9'd1) begin
                            // Overrun without last: flag it, but only last ends the burst.
                            len_error <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: scoreboard of expected beats and grants,
// plus a strict-priority instance kept under constant contention.
module tb_axi_read_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        m0_ar_valid, m0_ar_ready, m0_r_valid, m0_r_ready, m0_r_payload_last;
    logic [31:0] m0_ar_payload_addr, m0_r_payload_data;
    logic [7:0]  m0_ar_payload_len;
    logic [1:0]  m0_ar_payload_burst;
    logic        m1_ar_valid, m1_ar_ready, m1_r_valid, m1_r_ready, m1_r_payload_last;
    logic [31:0] m1_ar_payload_addr, m1_r_payload_data;
    logic [7:0]  m1_ar_payload_len;
    logic [1:0]  m1_ar_payload_burst;
    logic        s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, s_r_payload_last;
    logic [31:0] s_ar_payload_addr, s_r_payload_data;
    logic [7:0]  s_ar_payload_len;
    logic [1:0]  s_ar_payload_burst;
    logic        grant, len_error;

    logic        st_m0_ar_ready, st_m1_ar_ready, st_m0_r_valid, st_m1_r_valid;
    logic        st_m0_r_last, st_m1_r_last, st_s_ar_valid, st_s_r_ready, st_grant, st_len_error;
    logic [31:0] st_m0_r_data, st_m1_r_data, st_s_ar_addr;
    logic [7:0]  st_s_ar_len;
    logic [1:0]  st_s_ar_burst;

    int n_chk = 0;
    int n_fail = 0;
    logic [32:0] beat_q[$];
    int          grant_q[$];

    axi_read_arbiter #(.VIDEO_STREAK(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready),
        .m0_ar_payload_addr(m0_ar_payload_addr), .m0_ar_payload_len(m0_ar_payload_len),
        .m0_ar_payload_burst(m0_ar_payload_burst),
        .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready),
        .m0_r_payload_data(m0_r_payload_data), .m0_r_payload_last(m0_r_payload_last),
        .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready),
        .m1_ar_payload_addr(m1_ar_payload_addr), .m1_ar_payload_len(m1_ar_payload_len),
        .m1_ar_payload_burst(m1_ar_payload_burst),
        .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready),
        .m1_r_payload_data(m1_r_payload_data), .m1_r_payload_last(m1_r_payload_last),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
        .s_ar_payload_addr(s_ar_payload_addr), .s_ar_payload_len(s_ar_payload_len),
        .s_ar_payload_burst(s_ar_payload_burst),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
        .s_r_payload_data(s_r_payload_data), .s_r_payload_last(s_r_payload_last),
        .grant(grant), .len_error(len_error)
    );

    // Strict-priority instance: both masters always request, memory always ready.
    axi_read_arbiter #(.VIDEO_STREAK(0)) u_strict (
        .clk(clk), .reset_n(reset_n),
        .m0_ar_valid(1'b1), .m0_ar_ready(st_m0_ar_ready),
        .m0_ar_payload_addr(32'h0000_1000), .m0_ar_payload_len(8'd0),
        .m0_ar_payload_burst(2'b01),
        .m0_r_valid(st_m0_r_valid), .m0_r_ready(1'b1),
        .m0_r_payload_data(st_m0_r_data), .m0_r_payload_last(st_m0_r_last),
        .m1_ar_valid(1'b1), .m1_ar_ready(st_m1_ar_ready),
        .m1_ar_payload_addr(32'h0000_2000), .m1_ar_payload_len(8'd0),
        .m1_ar_payload_burst(2'b01),
        .m1_r_valid(st_m1_r_valid), .m1_r_ready(1'b1),
        .m1_r_payload_data(st_m1_r_data), .m1_r_payload_last(st_m1_r_last),
        .s_ar_valid(st_s_ar_valid), .s_ar_ready(1'b1),
        .s_ar_payload_addr(st_s_ar_addr), .s_ar_payload_len(st_s_ar_len),
        .s_ar_payload_burst(st_s_ar_burst),
        .s_r_valid(1'b1), .s_r_ready(st_s_r_ready),
        .s_r_payload_data(32'h0), .s_r_payload_last(1'b1),
        .grant(st_grant), .len_error(st_len_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ar(input int m, input logic v, input logic [31:0] a, input logic [7:0] l);
        if (m == 0) begin
            m0_ar_valid = v; m0_ar_payload_addr = a; m0_ar_payload_len = l; m0_ar_payload_burst = 2'b01;
        end else begin
            m1_ar_valid = v; m1_ar_payload_addr = a; m1_ar_payload_len = l; m1_ar_payload_burst = 2'b10;
        end
    endtask

    task automatic set_r_ready(input int m, input logic v);
        if (m == 0) m0_r_ready = v; else m1_r_ready = v;
    endtask

    function automatic logic ar_ready(input int m);
        return (m == 0) ? m0_ar_ready : m1_ar_ready;
    endfunction
    function automatic logic r_valid(input int m);
        return (m == 0) ? m0_r_valid : m1_r_valid;
    endfunction
    function automatic logic [31:0] r_data(input int m);
        return (m == 0) ? m0_r_payload_data : m1_r_payload_data;
    endfunction
    function automatic logic r_last(input int m);
        return (m == 0) ? m0_r_payload_last : m1_r_payload_last;
    endfunction

    // One burst from master m; memory returns nbeats beats, data = addr + index.
    task automatic do_burst(input int m, input logic [31:0] a, input logic [7:0] l, input int nbeats,
                            input int ar_stall, input int gap_at, input int gap_n, input int rst_at);
        int t;
        int i;
        int gapc;
        logic rr;
        logic [32:0] e;
        for (int k = 0; k < nbeats; k++) beat_q.push_back({(k == nbeats - 1), a + 32'(k)});
        @(negedge clk);
        set_ar(m, 1'b1, a, l);
        #1;
        t = 0;
        while (!ar_ready(m) && t < 20) begin
            @(negedge clk); #1; t++;
        end
        chk("ar_handshake", 32'(ar_ready(m)), 1);
        chk("s_ar_valid_pre", 32'(s_ar_valid), 0);
        for (int k = 0; k <= ar_stall; k++) begin
            @(negedge clk);
            if (k == 0) set_ar(m, 1'b0, 32'h0, 8'h0);
            set_ar(1 - m, (k < ar_stall), 32'hdead_0000, 8'd5);
            s_ar_ready = (k == ar_stall);
            #1;
            chk("s_ar_valid_hold", 32'(s_ar_valid), 1);
            chk("s_ar_addr", s_ar_payload_addr, a);
            chk("s_ar_len", 32'(s_ar_payload_len), 32'(l));
            chk("grant", 32'(grant), m);
            chk("no_second_grant", {30'h0, m1_ar_ready, m0_ar_ready}, 0);
        end
        i = 0; gapc = 0; t = 0;
        while (i < nbeats && t < 600) begin
            @(negedge clk);
            s_ar_ready = 1'b0;
            t++;
            rr = !(i == gap_at && gapc < gap_n);
            if (!rr) gapc++;
            s_r_valid = 1'b1;
            s_r_payload_data = a + 32'(i);
            s_r_payload_last = (i == nbeats - 1);
            set_r_ready(m, rr);
            if (i == rst_at) begin
                reset_n = 1'b0;
                #1;
                chk("rst_s_ar_valid", 32'(s_ar_valid), 0);
                chk("rst_m0_r_valid", 32'(m0_r_valid), 0);
                chk("rst_m1_r_valid", 32'(m1_r_valid), 0);
                chk("rst_len_error", 32'(len_error), 0);
                chk("rst_s_r_ready", 32'(s_r_ready), 0);
                chk("rst_s_ar_addr", s_ar_payload_addr, 0);
                beat_q.delete();
                s_r_valid = 1'b0;
                s_r_payload_last = 1'b0;
                return;
            end
            #1;
            chk("s_r_ready", 32'(s_r_ready), 32'(rr));
            chk("r_valid_granted", 32'(r_valid(m)), 1);
            chk("r_valid_other", 32'(r_valid(1 - m)), 0);
            if (rr) begin
                if (beat_q.size() == 0) begin
                    chk("beat_q_underflow", 1, 0);
                end else begin
                    e = beat_q.pop_front();
                    chk("r_data", r_data(m), e[31:0]);
                    chk("r_last", 32'(r_last(m)), 32'(e[32]));
                end
                i++;
            end
        end
        chk("burst_beats", i, nbeats);
        chk("gap_cycles", gapc, (gap_at >= 0 && gap_at < nbeats) ? gap_n : 0);
        @(negedge clk);
        s_r_valid = 1'b0;
        s_r_payload_last = 1'b0;
        set_r_ready(m, 1'b1);
        #1;
        chk("idle_no_r_valid", {30'h0, m1_r_valid, m0_r_valid}, 0);
    endtask

    initial begin
        int t;
        int g;
        int st0;
        int st1;
        reset_n = 1'b0;
        set_ar(0, 1'b0, 32'h0, 8'h0);
        set_ar(1, 1'b1, 32'h0, 8'h0);
        m0_r_ready = 1'b1; m1_r_ready = 1'b1;
        s_ar_ready = 1'b0; s_r_valid = 1'b1;
        s_r_payload_data = 32'h0; s_r_payload_last = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_s_ar_valid", 32'(s_ar_valid), 0);
        chk("reset_s_ar_addr", s_ar_payload_addr, 0);
        chk("reset_grant", 32'(grant), 0);
        chk("reset_len_error", 32'(len_error), 0);
        chk("reset_m1_ar_ready", 32'(m1_ar_ready), 0);
        chk("reset_r_valid", {30'h0, m1_r_valid, m0_r_valid}, 0);
        @(negedge clk);
        set_ar(1, 1'b0, 32'h0, 8'h0);
        s_r_valid = 1'b0;
        reset_n = 1'b1;

        // Contention with VIDEO_STREAK=4, single-beat bursts.
        foreach (grant_q[k]) grant_q[k] = 0;
        for (int k = 0; k < 10; k++) grant_q.push_back((k % 5 == 4) ? 1 : 0);
        @(negedge clk);
        set_ar(0, 1'b1, 32'h0000_0a00, 8'd0);
        set_ar(1, 1'b1, 32'h0000_0b00, 8'd0);
        s_ar_ready = 1'b1; s_r_valid = 1'b1; s_r_payload_last = 1'b1;
        t = 0; st0 = 0; st1 = 0;
        #1;
        while (grant_q.size() != 0 && t < 60) begin
            if (st_m0_ar_ready) st0++;
            if (st_m1_ar_ready) st1++;
            if (m0_ar_ready || m1_ar_ready) begin
                g = grant_q.pop_front();
                chk("grant_seq", 32'(m1_ar_ready), g);
                chk("one_ready", 32'(m0_ar_ready & m1_ar_ready), 0);
            end
            @(negedge clk); #1; t++;
        end
        chk("grant_seq_done", grant_q.size(), 0);
        chk("strict_m1_never", st1, 0);
        chk("strict_m0_granted", 32'(st0 >= 5), 1);
        set_ar(0, 1'b0, 32'h0, 8'h0);
        set_ar(1, 1'b0, 32'h0, 8'h0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        s_ar_ready = 1'b0; s_r_valid = 1'b0; s_r_payload_last = 1'b0;
        #1;
        chk("contention_len_error", 32'(len_error), 0);

        // Single 64-beat video burst.
        do_burst(0, 32'h1000_0000, 8'd63, 64, 0, -1, 0, -1);
        chk("video_len_error", 32'(len_error), 0);

        // Address back-pressure, then r_ready gap mid-burst.
        do_burst(1, 32'h2000_0100, 8'd7, 8, 5, 3, 3, -1);
        chk("bp_len_error", 32'(len_error), 0);

        // Early last on beat 2 of a 4-beat burst; flag is sticky.
        do_burst(1, 32'h3000_0000, 8'd3, 2, 0, -1, 0, -1);
        chk("mismatch_len_error", 32'(len_error), 1);
        do_burst(0, 32'h3000_1000, 8'd0, 1, 0, -1, 0, -1);
        chk("sticky_len_error", 32'(len_error), 1);

        // Asynchronous reset on beat 10 of a 64-beat burst.
        do_burst(0, 32'h4000_0000, 8'd63, 64, 0, -1, 0, 9);
        set_ar(1, 1'b1, 32'h4444_0000, 8'd0);
        #1;
        chk("rst_m1_ar_ready", 32'(m1_ar_ready), 0);
        set_ar(1, 1'b0, 32'h0, 8'h0);
        @(negedge clk);
        reset_n = 1'b1;
        do_burst(0, 32'h5000_0000, 8'd3, 4, 0, -1, 0, -1);
        chk("post_reset_len_error", 32'(len_error), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
